// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw roadside sensors into pedestrian/ambulance/density requests for the light controller.
// Latency: 2-flop sync plus debounce/qualify; pedestrian at edge 3+DEBOUNCE_CYCLES, ambulance at edge 2+AMB_QUAL, density per window. No backpressure.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AMB_QUAL        = 3,
  parameter int AMB_HOLD        = 12,
  parameter int WINDOW_CYCLES   = 64,
  parameter int TH_LOW          = 4,
  parameter int TH_MED          = 8,
  parameter int TH_HIGH         = 12,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ped_button,
  input  logic       siren_detect,
  input  logic       car_pulse,
  input  logic       red,
  output logic       pedestrian,
  output logic       ambulance,
  output logic [1:0] traffic_density
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int QW    = $clog2(AMB_QUAL + 1);
  localparam int HW    = $clog2(AMB_HOLD + 1);
  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  localparam logic [1:0] A_IDLE   = 2'd0;
  localparam logic [1:0] A_QUAL   = 2'd1;
  localparam logic [1:0] A_ACTIVE = 2'd2;
  localparam logic [1:0] A_HOLD   = 2'd3;

  logic btn_s1, btn_s2, siren_s1, siren_s2, car_s1, car_s2;
  logic car_d, red_d;
  logic deb_level, deb_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic [1:0] amb_state, amb_nxt;
  logic [QW-1:0] qual_cnt, qual_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] veh_cnt, veh_inc;
  logic [1:0] dens_code;
  logic car_edge, win_last, ped_set, ped_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      siren_s1 <= 1'b0;
      siren_s2 <= 1'b0;
      car_s1   <= 1'b0;
      car_s2   <= 1'b0;
      car_d    <= 1'b0;
      red_d    <= 1'b0;
    end else begin
      btn_s1   <= ped_button;
      btn_s2   <= btn_s1;
      siren_s1 <= siren_detect;
      siren_s2 <= siren_s1;
      car_s1   <= car_pulse;
      car_s2   <= car_s1;
      car_d    <= car_s2;
      red_d    <= red;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      deb_prev <= deb_level;
      if (btn_s2 != deb_level) begin
        if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_level <= btn_s2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign ped_set = deb_level & ~deb_prev;
  assign ped_clr = red & ~red_d;

  // A new press landing on the red entry must not be lost, so set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pedestrian <= 1'b0;
    end else if (ped_set) begin
      pedestrian <= 1'b1;
    end else if (ped_clr) begin
      pedestrian <= 1'b0;
    end
  end

  always_comb begin
    amb_nxt  = amb_state;
    qual_nxt = qual_cnt;
    hold_nxt = hold_cnt;
    case (amb_state)
      A_IDLE: begin
        if (siren_s2) begin
          qual_nxt = QW'(1);
          amb_nxt  = A_QUAL;
        end
      end
      A_QUAL: begin
        if (!siren_s2) begin
          amb_nxt = A_IDLE;
        end else begin
          qual_nxt = qual_cnt + QW'(1);
          if (qual_nxt == QW'(AMB_QUAL)) amb_nxt = A_ACTIVE;
        end
      end
      A_ACTIVE: begin
        if (!siren_s2) begin
          hold_nxt = '0;
          amb_nxt  = A_HOLD;
        end
      end
      A_HOLD: begin
        if (siren_s2) begin
          amb_nxt = A_ACTIVE;
        end else if (hold_cnt == HW'(AMB_HOLD - 1)) begin
          amb_nxt = A_IDLE;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: amb_nxt = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amb_state <= A_IDLE;
      qual_cnt  <= '0;
      hold_cnt  <= '0;
      ambulance <= 1'b0;
    end else begin
      amb_state <= amb_nxt;
      qual_cnt  <= qual_nxt;
      hold_cnt  <= hold_nxt;
      ambulance <= (amb_nxt == A_ACTIVE) || (amb_nxt == A_HOLD);
    end
  end

  assign car_edge = car_s2 & ~car_d;
  assign win_last = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
  // An edge on the closing cycle still belongs to the closing window.
  assign veh_inc  = (car_edge && (veh_cnt != {CNT_W{1'b1}})) ? veh_cnt + CNT_W'(1) : veh_cnt;

  always_comb begin
    if (int'(veh_inc) < TH_LOW)       dens_code = 2'b00;
    else if (int'(veh_inc) < TH_MED)  dens_code = 2'b01;
    else if (int'(veh_inc) < TH_HIGH) dens_code = 2'b10;
    else                              dens_code = 2'b11;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt         <= '0;
      veh_cnt         <= '0;
      traffic_density <= 2'b00;
    end else if (win_last) begin
      win_cnt         <= '0;
      veh_cnt         <= '0;
      traffic_density <= dens_code;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      veh_cnt <= veh_inc;
    end
  end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed pedestrian/siren sequences plus a density scoreboard.
module tb_traffic_sensor_conditioner;

  localparam int AMB_HOLD = 12;
  localparam int WIN      = 64;
  localparam int TH_LOW   = 4;
  localparam int TH_MED   = 8;
  localparam int TH_HIGH  = 12;

  logic       clk;
  logic       reset_n;
  logic       ped_button;
  logic       siren_detect;
  logic       car_pulse;
  logic       red;
  logic       pedestrian;
  logic       ambulance;
  logic [1:0] traffic_density;

  int errs;
  int checks;
  int ecount;
  logic [1:0] exp_q[$];
  logic [1:0] dens_model;

  // Pulses per window; ex_tab adds one pulse whose sync edge lands on the closing cycle.
  int n_tab[6]  = '{3, 8, 11, 3, 0, 20};
  int ex_tab[6] = '{0, 0, 0, 1, 0, 0};

  traffic_sensor_conditioner dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ped_button      (ped_button),
    .siren_detect    (siren_detect),
    .car_pulse       (car_pulse),
    .red             (red),
    .pedestrian      (pedestrian),
    .ambulance       (ambulance),
    .traffic_density (traffic_density)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  function automatic logic [1:0] dens_class(input int c);
    if (c < TH_LOW) return 2'b00;
    if (c < TH_MED) return 2'b01;
    if (c < TH_HIGH) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic car_at(input int e);
    int w;
    int off;
    w   = (e - 1) / WIN;
    off = (e - 1) % WIN;
    if (off < 3 * n_tab[w] && (off % 3) != 2) return 1'b1;
    if (ex_tab[w] != 0 && (off == 61 || off == 62)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp;
    errs = 0; checks = 0; ecount = 0;
    dens_model   = 2'b00;
    reset_n      = 1'b0;
    ped_button   = 1'b0;
    siren_detect = 1'b0;
    car_pulse    = 1'b0;
    red          = 1'b0;
    repeat (3) step();
    chk("rst_ped", {7'd0, pedestrian}, 8'd0);
    chk("rst_amb", {7'd0, ambulance}, 8'd0);
    chk("rst_dens", {6'd0, traffic_density}, 8'd0);
    reset_n = 1'b1;
    ecount  = 0;

    // Clean press: pedestrian rises after edge 7, red entry clears it.
    ped_button = 1'b1;
    repeat (6) step();
    chk("ped_edge6", {7'd0, pedestrian}, 8'd0);
    step();
    chk("ped_edge7", {7'd0, pedestrian}, 8'd1);
    red = 1'b1;
    step();
    chk("ped_clear", {7'd0, pedestrian}, 8'd0);
    red = 1'b0;
    ped_button = 1'b0;
    repeat (12) step();

    // Bounce: toggling every two cycles never debounces.
    for (int i = 0; i < 20; i++) begin
      ped_button = ((i / 2) % 2) == 0;
      step();
      chk("bounce", {7'd0, pedestrian}, 8'd0);
    end
    ped_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bounce_idle", {7'd0, pedestrian}, 8'd0);
    end

    // Set and clear in the same cycle: set wins.
    ped_button = 1'b1;
    repeat (6) step();
    red = 1'b1;
    step();
    chk("collide", {7'd0, pedestrian}, 8'd1);
    step();
    chk("collide_hold", {7'd0, pedestrian}, 8'd1);
    red = 1'b0;
    ped_button = 1'b0;
    repeat (12) step();

    // Two-cycle siren blip is not qualified.
    siren_detect = 1'b1;
    step();
    step();
    siren_detect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("amb_blip", {7'd0, ambulance}, 8'd0);
    end

    // Sustained siren: ambulance after edge 5, then AMB_HOLD cycles in hold.
    siren_detect = 1'b1;
    repeat (4) step();
    chk("amb_edge4", {7'd0, ambulance}, 8'd0);
    step();
    chk("amb_edge5", {7'd0, ambulance}, 8'd1);
    repeat (6) step();
    siren_detect = 1'b0;
    step();
    step();
    chk("amb_sync_lag", {7'd0, ambulance}, 8'd1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!ambulance) break;
      n++;
    end
    chk("amb_hold_len", 8'(n), 8'(AMB_HOLD));
    repeat (4) step();

    // Reassert during hold: no gap, no requalification.
    siren_detect = 1'b1;
    repeat (5) step();
    chk("amb_re_on", {7'd0, ambulance}, 8'd1);
    siren_detect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("amb_re_drop", {7'd0, ambulance}, 8'd1);
    end
    siren_detect = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("amb_re_hold", {7'd0, ambulance}, 8'd1);
    end
    siren_detect = 1'b0;
    repeat (20) step();
    chk("amb_idle", {7'd0, ambulance}, 8'd0);

    // Density phase starts from a fresh reset so windows align with edge numbers.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    ecount = 0;
    for (int e = 1; e <= 6 * WIN; e++) begin
      int w;
      int off;
      w   = (e - 1) / WIN;
      off = (e - 1) % WIN;
      car_pulse = car_at(e);
      if (off == 0) exp_q.push_back(dens_class(n_tab[w] + ex_tab[w]));
      step();
      if (off == 31) chk("dens_mid", {6'd0, traffic_density}, {6'd0, dens_model});
      if (off == WIN - 1) begin
        if (exp_q.size() == 0) begin
          chk("dens_q_empty", 8'd1, 8'd0);
        end else begin
          exp = exp_q.pop_front();
          chk("dens_win", {6'd0, traffic_density}, {6'd0, exp});
          dens_model = exp;
        end
      end
    end
    car_pulse = 1'b0;

    // Build up pedestrian=1, ambulance in hold and density 11, then reset asynchronously.
    ped_button   = 1'b1;
    siren_detect = 1'b1;
    repeat (10) step();
    siren_detect = 1'b0;
    repeat (4) step();
    chk("pre_rst_ped", {7'd0, pedestrian}, 8'd1);
    chk("pre_rst_amb", {7'd0, ambulance}, 8'd1);
    chk("pre_rst_dens", {6'd0, traffic_density}, 8'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ped", {7'd0, pedestrian}, 8'd0);
    chk("async_rst_amb", {7'd0, ambulance}, 8'd0);
    chk("async_rst_dens", {6'd0, traffic_density}, 8'd0);
    ped_button = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
